// File: rtl/press_judge_pkg.sv
// Shared definitions for the press_judge rhythm-game judge.
package press_judge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WINDOW = 2'd1,
        DONE   = 2'd2
    } judge_state_t;

    localparam int unsigned UP       = 0;
    localparam int unsigned DOWN     = 1;
    localparam int unsigned LEFT     = 2;
    localparam int unsigned RIGHT    = 3;
    localparam int unsigned N_ARROWS = 4;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < N_ARROWS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/press_judge_if.sv
// Control, button and result signals of one press_judge player.
interface press_judge_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             clr;
    logic             beat_tick;
    logic [3:0]       arrow;
    logic [3:0]       btn;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             hit_pulse;
    logic             err_pulse;
    logic             judged;

    modport master (
        output en, clr, beat_tick, arrow, btn,
        input  hit_cnt, err_cnt, hit_pulse, err_pulse, judged
    );

    modport slave (
        input  en, clr, beat_tick, arrow, btn,
        output hit_cnt, err_cnt, hit_pulse, err_pulse, judged
    );
endinterface

// File: rtl/press_judge_debounce.sv
// One button bit: 2-flop synchronizer, debouncer, rising-edge press strobe.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);
    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Synchronize, then accept the new level once it differed for DEB_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_btn;
            r_s2    <= r_s1;
            r_press <= 1'b0;
            if (r_s2 != r_level) begin
                if (r_cnt == LAST) begin
                    r_level <= r_s2;
                    r_press <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/press_judge.sv
// Beat judge: debounces four arrow buttons and scores hits, wrong presses and misses.
module press_judge
    import press_judge_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    press_judge_if.slave bus
);
    logic [3:0]       w_press;
    logic [3:0]       w_press_en;
    logic             w_beat;
    judge_state_t     r_state;
    judge_state_t     w_state_b;
    judge_state_t     w_state_next;
    logic [3:0]       r_target;
    logic [3:0]       r_got;
    logic [3:0]       w_tgt_b;
    logic [3:0]       w_got_b;
    logic [3:0]       w_good;
    logic [3:0]       w_bad;
    logic [3:0]       w_got_next;
    logic             w_miss;
    logic             w_hit;
    logic [2:0]       w_err_n;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W:0]   w_err_sum;
    logic             r_hit_pulse;
    logic             r_err_pulse;

    for (genvar gi = 0; gi < N_ARROWS; gi++) begin : g_btn
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn   (bus.btn[gi]),
            .o_press (w_press[gi])
        );
    end

    assign w_beat     = bus.en & bus.beat_tick;
    assign w_press_en = bus.en ? w_press : 4'b0000;

    // State register; clr forces IDLE ahead of any event.
    always_ff @(posedge clk) begin
        if (!rst_n)       r_state <= IDLE;
        else if (bus.clr) r_state <= IDLE;
        else              r_state <= w_state_next;
    end

    // Next state: close the old window on a beat first, then judge presses against the new target.
    always_comb begin
        w_state_b = r_state;
        w_tgt_b   = r_target;
        w_got_b   = r_got;
        w_miss    = 1'b0;
        if (w_beat) begin
            w_miss    = (r_state == WINDOW) && (r_got != r_target);
            w_tgt_b   = bus.arrow;
            w_got_b   = '0;
            w_state_b = (bus.arrow == 4'b0000) ? DONE : WINDOW;
        end
        w_good = '0;
        w_bad  = '0;
        case (w_state_b)
            WINDOW: begin
                w_good = w_press_en & w_tgt_b & ~w_got_b;
                w_bad  = w_press_en & ~(w_tgt_b & ~w_got_b);
            end
            DONE:    w_bad = w_press_en;
            default: ;
        endcase
        w_got_next   = w_got_b | w_good;
        w_state_next = w_state_b;
        if (w_state_b == WINDOW && w_got_next == w_tgt_b) w_state_next = DONE;
        if (!bus.en) w_state_next = IDLE;
    end

    // Per-cycle scoring: completion strobe and number of error events.
    always_comb begin
        w_hit     = bus.en && (w_state_b == WINDOW) && (w_got_next == w_tgt_b);
        w_err_n   = popcount4(w_bad) + {2'b00, w_miss};
        w_err_sum = {1'b0, r_err_cnt} + (CNT_W + 1)'(w_err_n);
    end

    // Target/got tracking and saturating counters with their strobes.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr) begin
            r_target    <= '0;
            r_got       <= '0;
            r_hit_cnt   <= '0;
            r_err_cnt   <= '0;
            r_hit_pulse <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_target    <= w_tgt_b;
            r_got       <= w_got_next;
            r_hit_pulse <= w_hit;
            r_err_pulse <= (w_err_n != 3'd0);
            if (w_hit && r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            r_err_cnt <= w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
        end
    end

    assign bus.hit_cnt   = r_hit_cnt;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.hit_pulse = r_hit_pulse;
    assign bus.err_pulse = r_err_pulse;
    assign bus.judged    = (r_state == DONE);

endmodule
